chunk_write_collector: RTL and testbench
========================================

CHUNK_WRITE_COLLECTOR -- requirements
Module: ChunkWriteCollector

Interface
REQ-001 SHALL have parameters: GBW, default TauCfg::GLOBAL_ADDR_BW, DRAM line address width; DBW, default TauCfg::DATA_BW, data word width; VSIZE, default TauCfg::VSIZE, warp lanes; CSIZE, default TauCfg::CACHE_SIZE, words per DRAM line (CSIZE >= VSIZE, both powers of 2).
REQ-002 SHALL derive CC_BW = clog2(CSIZE) and CV_BW1 = clog2(VSIZE+1).
REQ-003 SHALL have ports, clock and reset first:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-low
- i_cmd_rdy  in  1  write command valid
- o_cmd_ack  out  1  command accepted this cycle
- i_cmd_addr  in  GBW  DRAM line address
- i_cmd_addrofs  in  CC_BW  first word position in line
- i_cmd_len  in  CV_BW1  valid lanes, 1..VSIZE
- i_cmd_islast  in  1  flush line after this command
- i_cmd_data  in  DBW x [VSIZE]  lane data
- o_dramw_rdy  out  1  DRAM write line valid
- i_dramw_ack  in  1  DRAM write taken
- o_dramwa  out  GBW  line address
- o_dramwd  out  DBW x [CSIZE]  line data
- o_dramw_mask  out  CSIZE  per-word write enable
- o_busy  out  1  buffer holds unflushed words or flush pending

Function
REQ-004 SHALL implement FSM states IDLE (mask empty), COLLECT (mask non-empty, line open), FLUSH (o_dramw_rdy=1).
REQ-005 SHALL assert o_cmd_ack = i_cmd_rdy combinationally only in IDLE, or in COLLECT when i_cmd_addr equals held line address; never in FLUSH.
REQ-006 On accepted command, SHALL write lane i (i < i_cmd_len) into line word i_cmd_addrofs+i and set mask bit; lanes i >= len SHALL leave buffer untouched.
REQ-007 Later write to an already-masked word SHALL overwrite its data (last write wins).
REQ-008 In IDLE, accepted command SHALL latch i_cmd_addr as held line address.
REQ-009 Accepted command with islast=0 SHALL go to COLLECT; with islast=1 SHALL go to FLUSH next cycle (o_dramw_rdy rises one cycle after ack).
REQ-010 In COLLECT with i_cmd_rdy=1 and address mismatch, SHALL not ack, SHALL go to FLUSH next cycle; command is accepted after flush completes (in IDLE).
REQ-011 In FLUSH, o_dramwa/o_dramwd/o_dramw_mask SHALL be registered and stable until i_dramw_ack; on ack, SHALL clear mask and go to IDLE next cycle.
REQ-012 o_dramwd words with mask bit 0 SHALL be don't-care for DRAM; implementation SHALL not require clearing data.
REQ-013 SHALL never ack a command in the same cycle as i_dramw_ack (minimum one IDLE cycle between lines).
REQ-014 i_cmd_addrofs+i_cmd_len > CSIZE or i_cmd_len=0 SHALL be a caller error, flagged by simulation assertion; hardware SHALL drop out-of-range lanes (no wrap-around).
REQ-015 i_dramw_ack outside FLUSH SHALL be ignored.
REQ-016 o_busy SHALL equal (state != IDLE).

Reset
REQ-017 While i_rst=0 at posedge, SHALL enter IDLE, clear mask and held address, drive o_dramw_rdy=0, o_dramwa=0, o_dramw_mask=0; o_cmd_ack=0 during reset.
REQ-018 Reset mid-FLUSH SHALL discard pending line; no DRAM write issued.

Verification
REQ-019 (VSIZE=4, CSIZE=8) cmd addr=0x10, ofs=0, len=4, islast=1, data 1..4 -> one cycle later rdy=1, dramwa=0x10, mask=0x0F, words0..3=1..4.
REQ-020 cmd addr=0x10 ofs=0 len=4 islast=0, then addr=0x10 ofs=4 len=4 islast=1 -> single line, mask=0xFF, two command acks, one dramw transfer.
REQ-021 cmd addr=0x10 ofs=2 len=2 islast=0, then addr=0x20 ofs=0 len=1 islast=1 -> second cmd held unacked; line 0x10 mask=0x0C issued; after ack, line 0x20 mask=0x01 issued.
REQ-022 Two writes to addr=0x10 ofs=1 len=1 data 0xA then 0xB, islast on second -> word1=0xB, mask=0x02.
REQ-023 Hold i_dramw_ack=0 for 5 cycles in FLUSH with i_cmd_rdy=1 -> outputs stable, o_cmd_ack=0 throughout; ack -> IDLE, then command accepted.
REQ-024 Assert i_rst=0 during FLUSH -> next cycle o_dramw_rdy=0, mask=0, o_busy=0.

Source files
------------

// File: rtl/chunk_write_collector.sv
// chunk_write_collector: gathers partial warp writes into one DRAM line and flushes it with a word mask
module chunk_write_collector #(
   parameter  int GBW    = 32,
   parameter  int DBW    = 32,
   parameter  int VSIZE  = 4,
   parameter  int CSIZE  = 8,
   localparam int CC_BW  = $clog2(CSIZE),
   localparam int CV_BW1 = $clog2(VSIZE + 1)
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_cmd_rdy,
   output logic                        o_cmd_ack,
   input  logic [GBW-1:0]              i_cmd_addr,
   input  logic [CC_BW-1:0]            i_cmd_addrofs,
   input  logic [CV_BW1-1:0]           i_cmd_len,
   input  logic                        i_cmd_islast,
   input  logic [VSIZE-1:0][DBW-1:0]   i_cmd_data,
   output logic                        o_dramw_rdy,
   input  logic                        i_dramw_ack,
   output logic [GBW-1:0]              o_dramwa,
   output logic [CSIZE-1:0][DBW-1:0]   o_dramwd,
   output logic [CSIZE-1:0]            o_dramw_mask,
   output logic                        o_busy
);
   typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} state_t;
   state_t state, nxt;
   logic addr_hit;
   logic [CSIZE-1:0] wr_en;
   logic [CSIZE-1:0][DBW-1:0] wr_dat;
   assign addr_hit    = i_cmd_addr == o_dramwa;
   assign o_cmd_ack   = i_rst && i_cmd_rdy && (state == IDLE || (state == COLLECT && addr_hit));
   assign o_dramw_rdy = state == FLUSH;
   assign o_busy      = state != IDLE;
   // route accepted lanes onto their line words; lanes past the line end are dropped
   always_comb begin
      for (int j = 0; j < CSIZE; j++) begin
         wr_en[j]  = 1'b0;
         wr_dat[j] = o_dramwd[j];
         for (int i = 0; i < VSIZE; i++)
            if (o_cmd_ack && CV_BW1'(i) < i_cmd_len &&
                (CC_BW+1)'(i_cmd_addrofs) + (CC_BW+1)'(i) == (CC_BW+1)'(j)) begin
               wr_en[j]  = 1'b1;
               wr_dat[j] = i_cmd_data[i];
            end
      end
   end
   // next state: mismatch or islast closes the line, DRAM ack reopens the buffer
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = o_cmd_ack ? (i_cmd_islast ? FLUSH : COLLECT) : IDLE;
         COLLECT: nxt = (o_cmd_ack && i_cmd_islast) || (i_cmd_rdy && !addr_hit) ? FLUSH : COLLECT;
         FLUSH:   nxt = i_dramw_ack ? IDLE : FLUSH;
         default: nxt = IDLE;
      endcase
   end
   // state, held line address and word mask
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state        <= IDLE;
         o_dramwa     <= '0;
         o_dramw_mask <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && o_cmd_ack) o_dramwa <= i_cmd_addr;
         o_dramw_mask <= (state == FLUSH && i_dramw_ack) ? '0 : (o_dramw_mask | wr_en);
      end
   end
   // line data needs no reset: unmasked words are ignored by DRAM
   always_ff @(posedge i_clk) begin
      o_dramwd <= wr_dat;
   end
   // caller must keep commands inside one line with at least one lane
   a_cmd_range: assert property (@(posedge i_clk) disable iff (!i_rst)
      o_cmd_ack |-> (i_cmd_len != 0 && int'(i_cmd_addrofs) + int'(i_cmd_len) <= CSIZE));
endmodule

// File: tb/tb_chunk_write_collector.sv
// tb_chunk_write_collector: directed scenario tests for the chunk write collector
module tb_chunk_write_collector;
   logic clk = 0, rst = 0, cmd_rdy = 0, cmd_ack, cmd_islast = 0;
   logic [31:0] cmd_addr = 0;
   logic [2:0] cmd_ofs = 0, cmd_len = 0;
   logic [3:0][31:0] cmd_data = '0;
   logic dramw_rdy, dramw_ack = 0, busy;
   logic [31:0] dramwa;
   logic [7:0][31:0] dramwd;
   logic [7:0] dramw_mask;
   int checks = 0, errors = 0;

   chunk_write_collector #(.GBW(32), .DBW(32), .VSIZE(4), .CSIZE(8)) dut (
      .i_clk(clk), .i_rst(rst), .i_cmd_rdy(cmd_rdy), .o_cmd_ack(cmd_ack),
      .i_cmd_addr(cmd_addr), .i_cmd_addrofs(cmd_ofs), .i_cmd_len(cmd_len),
      .i_cmd_islast(cmd_islast), .i_cmd_data(cmd_data), .o_dramw_rdy(dramw_rdy),
      .i_dramw_ack(dramw_ack), .o_dramwa(dramwa), .o_dramwd(dramwd),
      .o_dramw_mask(dramw_mask), .o_busy(busy));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic cmd(input logic [31:0] a, input logic [2:0] o, input logic [2:0] l, input logic last,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
      cmd_rdy = 1; cmd_addr = a; cmd_ofs = o; cmd_len = l; cmd_islast = last;
      cmd_data = {d3, d2, d1, d0};
      #1;
   endtask

   task automatic flush();
      dramw_ack = 1; tick(); dramw_ack = 0;
   endtask

   task automatic test_reset();
      rst = 0;
      cmd(32'h99, 0, 1, 1, 1, 0, 0, 0);
      checks++; if (cmd_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", cmd_ack); end
      tick(); tick();
      cmd_rdy = 0; rst = 1; #1;
      checks++; if (dramw_rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy got %b exp 0", dramw_rdy); end
      checks++; if (dramw_mask !== 8'h00) begin errors++; $display("FAIL rst_mask got %h exp 00", dramw_mask); end
      checks++; if (dramwa !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", dramwa); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
   endtask

   task automatic test_single_line();
      cmd(32'h10, 0, 4, 1, 1, 2, 3, 4);
      checks++; if (cmd_ack !== 1'b1) begin errors++; $display("FAIL single_ack got %b exp 1", cmd_ack); end
      tick(); cmd_rdy = 0; #1;
      checks++; if (dramw_rdy !== 1'b1) begin errors++; $display("FAIL single_rdy got %b exp 1", dramw_rdy); end
      checks++; if (dramwa !== 32'h10) begin errors++; $display("FAIL single_addr got %h exp 10", dramwa); end
      checks++; if (dramw_mask !== 8'h0F) begin errors++; $display("FAIL single_mask got %h exp 0f", dramw_mask); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (dramwd[i] !== 32'(i + 1)) begin errors++; $display("FAIL single_word%0d got %h exp %h", i, dramwd[i], i + 1); end
      end
      flush(); #1;
      checks++; if (dramw_rdy !== 1'b0) begin errors++; $display("FAIL single_done_rdy got %b exp 0", dramw_rdy); end
      checks++; if (dramw_mask !== 8'h00) begin errors++; $display("FAIL single_done_mask got %h exp 00", dramw_mask); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_done_busy got %b exp 0", busy); end
   endtask

   task automatic test_two_cmds();
      int acks = 0, xfers = 0;
      cmd(32'h10, 0, 4, 0, 5, 6, 7, 8);
      if (cmd_ack) acks++;
      tick();
      checks++; if (busy !== 1'b1 || dramw_rdy !== 1'b0) begin errors++; $display("FAIL two_collect got busy=%b rdy=%b exp 1 0", busy, dramw_rdy); end
      cmd(32'h10, 4, 4, 1, 9, 10, 11, 12);
      if (cmd_ack) acks++;
      tick(); cmd_rdy = 0; #1;
      checks++; if (dramw_mask !== 8'hFF) begin errors++; $display("FAIL two_mask got %h exp ff", dramw_mask); end
      checks++; if (dramwd[0] !== 32'd5 || dramwd[4] !== 32'd9 || dramwd[7] !== 32'd12) begin errors++; $display("FAIL two_words got %h %h %h exp 5 9 c", dramwd[0], dramwd[4], dramwd[7]); end
      for (int c = 0; c < 4; c++) begin
         if (dramw_rdy) xfers++;
         dramw_ack = dramw_rdy; tick();
      end
      dramw_ack = 0;
      checks++; if (acks !== 2) begin errors++; $display("FAIL two_acks got %0d exp 2", acks); end
      checks++; if (xfers !== 1) begin errors++; $display("FAIL two_xfers got %0d exp 1", xfers); end
   endtask

   task automatic test_addr_mismatch();
      cmd(32'h10, 2, 2, 0, 32'h21, 32'h22, 0, 0);
      tick();
      cmd(32'h20, 0, 1, 1, 32'h31, 0, 0, 0);
      checks++; if (cmd_ack !== 1'b0) begin errors++; $display("FAIL mis_hold_ack got %b exp 0", cmd_ack); end
      tick();
      checks++; if (dramw_rdy !== 1'b1 || dramwa !== 32'h10) begin errors++; $display("FAIL mis_line1 got rdy=%b addr=%h exp 1 10", dramw_rdy, dramwa); end
      checks++; if (dramw_mask !== 8'h0C) begin errors++; $display("FAIL mis_mask1 got %h exp 0c", dramw_mask); end
      checks++; if (dramwd[2] !== 32'h21 || dramwd[3] !== 32'h22) begin errors++; $display("FAIL mis_words1 got %h %h exp 21 22", dramwd[2], dramwd[3]); end
      dramw_ack = 1; #1;
      checks++; if (cmd_ack !== 1'b0) begin errors++; $display("FAIL mis_ack_on_dramack got %b exp 0", cmd_ack); end
      tick(); dramw_ack = 0; #1;
      checks++; if (cmd_ack !== 1'b1 || dramw_rdy !== 1'b0) begin errors++; $display("FAIL mis_idle_accept got ack=%b rdy=%b exp 1 0", cmd_ack, dramw_rdy); end
      tick(); cmd_rdy = 0; #1;
      checks++; if (dramwa !== 32'h20 || dramw_mask !== 8'h01) begin errors++; $display("FAIL mis_line2 got addr=%h mask=%h exp 20 01", dramwa, dramw_mask); end
      checks++; if (dramwd[0] !== 32'h31) begin errors++; $display("FAIL mis_word2 got %h exp 31", dramwd[0]); end
      flush();
   endtask

   task automatic test_overwrite();
      cmd(32'h10, 1, 1, 0, 32'hA, 0, 0, 0);
      tick();
      cmd(32'h10, 1, 1, 1, 32'hB, 0, 0, 0);
      tick(); cmd_rdy = 0; #1;
      checks++; if (dramwd[1] !== 32'hB) begin errors++; $display("FAIL ovw_word got %h exp b", dramwd[1]); end
      checks++; if (dramw_mask !== 8'h02) begin errors++; $display("FAIL ovw_mask got %h exp 02", dramw_mask); end
      flush();
   endtask

   task automatic test_stall();
      cmd(32'h40, 0, 2, 1, 32'h55, 32'h66, 0, 0);
      tick();
      cmd(32'h40, 0, 1, 1, 32'h77, 0, 0, 0);
      for (int c = 0; c < 5; c++) begin
         checks++; if (cmd_ack !== 1'b0 || dramw_rdy !== 1'b1 || dramw_mask !== 8'h03 || dramwa !== 32'h40 || dramwd[0] !== 32'h55 || dramwd[1] !== 32'h66)
            begin errors++; $display("FAIL stall_c%0d got ack=%b rdy=%b mask=%h addr=%h w0=%h exp 0 1 03 40 55", c, cmd_ack, dramw_rdy, dramw_mask, dramwa, dramwd[0]); end
         tick();
      end
      flush(); #1;
      checks++; if (cmd_ack !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stall_resume got ack=%b busy=%b exp 1 0", cmd_ack, busy); end
      tick(); cmd_rdy = 0; #1;
      checks++; if (dramw_mask !== 8'h01 || dramwd[0] !== 32'h77) begin errors++; $display("FAIL stall_next got mask=%h w0=%h exp 01 77", dramw_mask, dramwd[0]); end
      flush();
   endtask

   task automatic test_stray_ack();
      dramw_ack = 1;
      cmd(32'h60, 5, 3, 0, 32'hC5, 32'hC6, 32'hC7, 0);
      tick(); cmd_rdy = 0; tick();
      checks++; if (busy !== 1'b1 || dramw_rdy !== 1'b0) begin errors++; $display("FAIL stray_collect got busy=%b rdy=%b exp 1 0", busy, dramw_rdy); end
      dramw_ack = 0;
      cmd(32'h60, 0, 1, 1, 32'hC0, 0, 0, 0);
      tick(); cmd_rdy = 0; #1;
      checks++; if (dramw_mask !== 8'hE1 || dramwd[7] !== 32'hC7) begin errors++; $display("FAIL stray_line got mask=%h w7=%h exp e1 c7", dramw_mask, dramwd[7]); end
      flush();
   endtask

   task automatic test_reset_flush();
      cmd(32'h50, 0, 1, 1, 32'hEE, 0, 0, 0);
      tick(); cmd_rdy = 0; #1;
      checks++; if (dramw_rdy !== 1'b1) begin errors++; $display("FAIL rf_pre got %b exp 1", dramw_rdy); end
      rst = 0; tick(); rst = 1; #1;
      checks++; if (dramw_rdy !== 1'b0 || dramw_mask !== 8'h00 || busy !== 1'b0 || dramwa !== 32'h0)
         begin errors++; $display("FAIL rf_post got rdy=%b mask=%h busy=%b addr=%h exp 0 00 0 0", dramw_rdy, dramw_mask, busy, dramwa); end
   endtask

   initial begin
      test_reset();
      test_single_line();
      test_two_cmds();
      test_addr_mismatch();
      test_overwrite();
      test_stall();
      test_stray_ack();
      test_reset_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
